mmc_spi_master: RTL and testbench
=================================

Name: mmc_spi_master

Overview:
Synthesizable, parametrised SPI master for MMC/SD cards. It replaces simulation-only card access in the memory-card path.
- Word width, chip-select count, clock divider and SPI mode (CPOL/CPHA) are all configurable.
- Chip select can be held across back-to-back words.
- Sits between the disk-controller command sequencer and the card pins: card pins mmc_cs_n, mmc_sclk, mmc_di (to card), mmc_do (from card).

Parameters:
- DATA_W, 8, bits per transfer (MSB first).
- CS_N, 1, number of chip-select lines.
- DIV_W, 8, width of the clock-divider input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- div  in  DIV_W  half SCLK period minus one, in clk cycles (h = div+1).
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cs_mask  in  CS_N  chip selects to assert (1 = assert) for this transfer.
- cs_hold  in  1  keep CS asserted after this transfer.
- start  in  1  request a transfer; accepted only when busy=0.
- tx_data  in  DATA_W  word to send.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when rx_data is valid.
- rx_data  out  DATA_W  last received word.
- mmc_cs_n  out  CS_N  active-low chip selects.
- mmc_sclk  out  1  SPI clock.
- mmc_di  out  1  serial data to card.
- mmc_do  in  1  serial data from card.

Behaviour:
- Clock and reset: single clock, clk; synchronous active-high reset, reset.
- Reset values (also applied on reset mid-transfer, with the transfer aborted):
  - mmc_cs_n all 1, mmc_sclk 0, mmc_di 1.
  - busy 0, done 0, rx_data 0.
  - Held-CS state cleared.
- Start acceptance: start when busy=0 latches div, cpol, cpha, cs_mask, cs_hold and tx_data. busy rises next cycle. start while busy=1 is ignored.
- FSM states: IDLE, SETUP, SHIFT, DONE, TRAIL.
- IDLE:
  - mmc_sclk = latched cpol; mmc_di = 1 unless CS is held.
  - On accepted start: if CS is held and cs_mask equals the held mask, go to SHIFT. Otherwise drive mmc_cs_n = ~cs_mask and go to SETUP.
- SETUP:
  - Lasts h cycles.
  - If cpha=0, mmc_di = tx MSB from SETUP entry.
- SHIFT:
  - Lasts 2*DATA_W half-periods of h cycles each; mmc_sclk toggles at the end of each half-period.
  - cpha=0: sample mmc_do into the shift register on the leading edge; present the next bit on the trailing edge.
  - cpha=1: present a bit on the leading edge; sample on the trailing edge.
  - The last edge returns mmc_sclk to cpol.
- DONE:
  - One cycle: done=1, rx_data updated, busy still 1.
  - If cs_hold=1, go to IDLE with CS held and mmc_di = 1.
  - Otherwise go to TRAIL.
- TRAIL:
  - h cycles with CS still asserted, then mmc_cs_n all 1, busy=0, and go to IDLE.
- Latency, start cycle = 0, with setup: done is asserted at cycle 1 + h + 2*DATA_W*h. Without setup (held-CS path): cycle 1 + 2*DATA_W*h.
- div = 0 gives SCLK = clk/2.
- Changes to div, cpol or cpha inputs during a transfer have no effect.

Optional Feature:
- Macro MMC_SPI_CRC7_EN.
- When defined, adds ports crc_clr (in, 1) and crc7 (out, 7).
  - crc7 is updated with every transmitted bit, polynomial x^7+x^3+1.
  - crc_clr (when busy=0) zeroes it.
  - Reset value 0.
- When undefined, neither port exists and there is no CRC logic.

Decomposition:
- Package mmc_spi_pkg: FSM state enum; constant CRC7_POLY = 7'h09.
- Sub-module mmc_spi_clkgen: divider counter that emits half-period edge strobes (leading/trailing) while enabled.

Test Plan:
- Loopback (mmc_do tied to mmc_di), DATA_W=8, div=1, mode 0, tx 8'hA5 -> rx_data=8'hA5; done at cycle 35; 16 SCLK edges; CS deasserted 2 cycles after done.
- Card model returning 8'h3C, mode 3 (cpol=1, cpha=1), div=0 -> rx_data=8'h3C; mmc_sclk idles high before and after.
- cs_hold=1, then a second start with the same mask, div=1 -> no SETUP, second done at cycle 33; mmc_cs_n stays low between words.
- start pulsed while busy -> ignored; rx_data reflects the first word only; only one done pulse.
- reset asserted mid-SHIFT -> next cycle mmc_cs_n=all 1, mmc_sclk=0, busy=0, no done pulse.
- With MMC_SPI_CRC7_EN: crc_clr, then send 40 00 00 00 00 -> crc7=7'h4A.

Source files
------------

// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the MMC/SD SPI master.
// Holds the FSM state encoding and the CRC7 (x^7+x^3+1) step used when MMC_SPI_CRC7_EN is defined.
package mmc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    TRAIL
  } state_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial step of the card CRC7, MSB-first, as the card computes it on command bytes.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_spi_clkgen.sv
// Half-period divider for the SPI master: while enabled, emits alternating leading/trailing
// edge strobes every div+1 clk cycles, starting with a leading strobe.
module mmc_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             lead,
  output logic             trail
);

  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             tick;

  assign tick  = en && (cnt == div);
  assign lead  = tick && !phase;
  assign trail = tick && phase;

  // Dropping en restarts the divider so every SHIFT burst begins with a full half-period.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmc_spi_master.sv
// SPI master for MMC/SD cards with configurable word width, chip selects, divider and mode.
// Optional CRC7 over transmitted bits is built when MMC_SPI_CRC7_EN is defined.
module mmc_spi_master
  import mmc_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CS_N   = 1,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_N-1:0]   cs_mask,
  input  logic              cs_hold,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [CS_N-1:0]   mmc_cs_n,
  output logic              mmc_sclk,
  output logic              mmc_di,
  input  logic              mmc_do
`ifdef MMC_SPI_CRC7_EN
  ,
  input  logic              crc_clr,
  output logic [6:0]        crc7
`endif
);

  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  logic [DIV_W-1:0]  div_l;
  logic              cpol_l;
  logic              cpha_l;
  logic [CS_N-1:0]   mask_l;
  logic              hold_l;
  logic              cs_held;
  logic [CS_N-1:0]   held_mask;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [BW-1:0]     bit_cnt;
  logic [DIV_W-1:0]  wait_cnt;
  logic              lead;
  logic              trail;
  logic              sample;
  logic              shift_out;

  mmc_spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (state == SHIFT),
    .div   (div_l),
    .lead  (lead),
    .trail (trail)
  );

  assign sample    = cpha_l ? trail : lead;
  assign shift_out = cpha_l ? lead : trail;
  assign rx_next   = {rx_sr[DATA_W-2:0], mmc_do};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      mmc_cs_n  <= '1;
      mmc_sclk  <= 1'b0;
      mmc_di    <= 1'b1;
      div_l     <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      mask_l    <= '0;
      hold_l    <= 1'b0;
      cs_held   <= 1'b0;
      held_mask <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mmc_sclk <= cpol_l;
          if (start) begin
            div_l    <= div;
            cpol_l   <= cpol;
            cpha_l   <= cpha;
            mask_l   <= cs_mask;
            hold_l   <= cs_hold;
            tx_sr    <= tx_data;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            busy     <= 1'b1;
            cs_held  <= 1'b0;
            mmc_sclk <= cpol;
            // Mode-0/2 cards sample on the very first edge, so the MSB must already be on the line.
            mmc_di   <= cpha ? 1'b1 : tx_data[DATA_W-1];
            if (cs_held && (cs_mask == held_mask)) begin
              state <= SHIFT;
            end else begin
              mmc_cs_n <= ~cs_mask;
              state    <= SETUP;
            end
          end
        end

        SETUP: begin
          if (wait_cnt == div_l) begin
            wait_cnt <= '0;
            state    <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (lead || trail) mmc_sclk <= ~mmc_sclk;
          if (sample) rx_sr <= rx_next;
          if (shift_out) begin
            mmc_di <= cpha_l ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          // Every bit ends on a trailing edge; in mode 1/3 the final sample lands on that same edge.
          if (trail) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              rx_data <= cpha_l ? rx_next : rx_sr;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end

        DONE: begin
          mmc_di   <= 1'b1;
          wait_cnt <= '0;
          if (hold_l) begin
            cs_held   <= 1'b1;
            held_mask <= mask_l;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= TRAIL;
          end
        end

        TRAIL: begin
          if (wait_cnt == div_l) begin
            wait_cnt <= '0;
            mmc_cs_n <= '1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMC_SPI_CRC7_EN
  // The bit on mmc_di at the sampling edge is the one the card actually receives.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc7 <= '0;
    end else if (!busy && crc_clr) begin
      crc7 <= '0;
    end else if ((state == SHIFT) && sample) begin
      crc7 <= crc7_step(crc7, mmc_di);
    end
  end
`endif

endmodule

// File: tb/tb_mmc_spi_master.sv
// Directed bench for mmc_spi_master: loopback and card-model transfers, held CS,
// ignored start, mid-transfer reset, and CRC7 when MMC_SPI_CRC7_EN is defined.
module tb_mmc_spi_master;

  localparam int DATA_W = 8;
  localparam int CS_N   = 1;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              cpha;
  logic [CS_N-1:0]   cs_mask;
  logic              cs_hold;
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic [CS_N-1:0]   mmc_cs_n;
  logic              mmc_sclk;
  logic              mmc_di;
  logic              mmc_do;
`ifdef MMC_SPI_CRC7_EN
  logic              crc_clr;
  logic [6:0]        crc7;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_rel = 0;
  int done_total = 0;
  int done_base = 0;
  int sclk_total = 0;
  int sclk_base = 0;
  logic sclk_prev;

  logic       loopback;
  logic [7:0] card_word;
  logic       card_do;
  int         card_idx;

  mmc_spi_master #(
    .DATA_W (DATA_W),
    .CS_N   (CS_N),
    .DIV_W  (DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .div      (div),
    .cpol     (cpol),
    .cpha     (cpha),
    .cs_mask  (cs_mask),
    .cs_hold  (cs_hold),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .mmc_cs_n (mmc_cs_n),
    .mmc_sclk (mmc_sclk),
    .mmc_di   (mmc_di),
    .mmc_do   (mmc_do)
`ifdef MMC_SPI_CRC7_EN
    ,
    .crc_clr  (crc_clr),
    .crc7     (crc7)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_total = done_total + 1;
    if (mmc_sclk != sclk_prev) sclk_total = sclk_total + 1;
    sclk_prev = mmc_sclk;
  end

  // Mode-3 card: shifts its word out MSB first on each falling SCLK edge while selected.
  assign mmc_do = loopback ? mmc_di : card_do;
  always @(negedge mmc_sclk or posedge mmc_cs_n[0]) begin
    if (mmc_cs_n[0]) begin
      card_idx = 0;
    end else begin
      card_do  = (card_idx < 8) ? card_word[3'(7 - card_idx)] : 1'b1;
      card_idx = card_idx + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DIV_W-1:0] d, input logic pol, input logic pha,
                               input logic [CS_N-1:0] m, input logic hold, input logic [7:0] tx);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n = n + 1;
    end
    if (busy) checkOutput("busy_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    div = d; cpol = pol; cpha = pha; cs_mask = m; cs_hold = hold; tx_data = tx;
    start = 1'b1;
    t0 = cyc;
    done_base = done_total;
    sclk_base = sclk_total;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_rel = cyc - t0;
      end
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; div = '0; cpol = 1'b0; cpha = 1'b0;
    cs_mask = '0; cs_hold = 1'b0; tx_data = '0;
    loopback = 1'b1; card_word = 8'h3C;
`ifdef MMC_SPI_CRC7_EN
    crc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cs_n", 32'(mmc_cs_n), 32'd1);
    checkOutput("rst_sclk", 32'(mmc_sclk), 32'd0);
    checkOutput("rst_di", 32'(mmc_di), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rx", 32'(rx_data), 32'd0);

    $display("[TB] loopback mode 0, div=1, A5");
    loopback = 1'b1;
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    @(negedge clk);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_cs_on", 32'(mmc_cs_n), 32'd0);
    waitDone();
    checkOutput("t1_rx", 32'(rx_data), 32'hA5);
    checkOutput("t1_latency", 32'(done_rel), 32'd35);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1_cs_trail", 32'(mmc_cs_n), 32'd0);
    @(negedge clk);
    checkOutput("t1_cs_off", 32'(mmc_cs_n), 32'd1);
    checkOutput("t1_busy_off", 32'(busy), 32'd0);
    checkOutput("t1_edges", 32'(sclk_total - sclk_base), 32'd16);
    checkOutput("t1_done_cnt", 32'(done_total - done_base), 32'd1);

    $display("[TB] card model mode 3, div=0, 3C");
    loopback = 1'b0;
    applyStimulus(8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h96);
    @(negedge clk);
    checkOutput("t2_sclk_pre", 32'(mmc_sclk), 32'd1);
    waitDone();
    checkOutput("t2_rx", 32'(rx_data), 32'h3C);
    checkOutput("t2_latency", 32'(done_rel), 32'd18);
    repeat (3) @(negedge clk);
    checkOutput("t2_sclk_post", 32'(mmc_sclk), 32'd1);
    checkOutput("t2_cs_off", 32'(mmc_cs_n), 32'd1);

    $display("[TB] held CS back-to-back words");
    loopback = 1'b1;
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
    waitDone();
    checkOutput("t3_rx1", 32'(rx_data), 32'h5A);
    checkOutput("t3_lat1", 32'(done_rel), 32'd35);
    @(negedge clk);
    checkOutput("t3_idle_busy", 32'(busy), 32'd0);
    checkOutput("t3_idle_cs", 32'(mmc_cs_n), 32'd0);
    checkOutput("t3_idle_di", 32'(mmc_di), 32'd1);
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    @(negedge clk);
    checkOutput("t3_cs_kept", 32'(mmc_cs_n), 32'd0);
    waitDone();
    checkOutput("t3_rx2", 32'(rx_data), 32'hC3);
    checkOutput("t3_lat2", 32'(done_rel), 32'd33);

    $display("[TB] start while busy is ignored");
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81);
    repeat (3) @(posedge clk);
    #1;
    tx_data = 8'h7E;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone();
    checkOutput("t4_rx", 32'(rx_data), 32'h81);
    repeat (10) @(negedge clk);
    checkOutput("t4_done_cnt", 32'(done_total - done_base), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);

`ifdef MMC_SPI_CRC7_EN
    $display("[TB] CRC7 over CMD0 frame");
    @(posedge clk);
    #1 crc_clr = 1'b1;
    @(posedge clk);
    #1 crc_clr = 1'b0;
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
    waitDone();
    for (int b = 0; b < 3; b++) begin
      applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      waitDone();
    end
    applyStimulus(8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    waitDone();
    checkOutput("crc7_cmd0", 32'(crc7), 32'h4A);
`endif

    $display("[TB] reset during SHIFT");
    applyStimulus(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_cs_n", 32'(mmc_cs_n), 32'd1);
    checkOutput("t5_sclk", 32'(mmc_sclk), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_di", 32'(mmc_di), 32'd1);
    checkOutput("t5_rx", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("t5_no_done", 32'(done_total - done_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
